// File: rtl/product_accumulator_pkg.sv
// rtl/product_accumulator_pkg.sv - shared state encoding and default widths for the product accumulator
// Contents:
//   acc_state_t    FSM state: ACCUM (taking products) / RESULT (holding a sum)
//   PROD_W_DEF     default product width, shared with the multiplier wrapper
//   ACC_W_DEF      default accumulator / result width
package product_accumulator_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } acc_state_t;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// rtl/product_accumulator_sat_adder.sv - unsigned saturating add of a zero-extended product onto the accumulator
// Ports:
//   acc       in   ACC_W   current accumulator value
//   addend    in   PROD_W  unsigned product, zero-extended before the add
//   sum       out  ACC_W   acc + addend, clamped to all-ones on overflow
//   overflow  out  1       the true sum did not fit in ACC_W bits
module product_accumulator_sat_adder #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow
);

    // One extra bit catches the carry out; ACC_W >= PROD_W keeps the pad width positive.
    logic [ACC_W:0] wide_sum;

    assign wide_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
    assign overflow = wide_sum[ACC_W];
    assign sum      = overflow ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - accumulates TERMS multiplier products into a saturating dot product with valid/ready on both sides
// Ports:
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous reset, active high
//   clear_i       in   1       synchronous abort of the partial or pending sum
//   prod_i        in   PROD_W  unsigned product from the multiplier
//   prod_valid_i  in   1       prod_i valid
//   prod_ready_o  out  1       product accepted this cycle when valid
//   sum_o         out  ACC_W   accumulated result, stable while sum_valid_o
//   sum_valid_o   out  1       result available
//   sum_ready_i   in   1       downstream takes the result
//   sat_o         out  1       result saturated, qualified by sum_valid_o
//   count_o       out  CNT_W   products accepted into the current sum
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int  PROD_W = PROD_W_DEF,
    parameter int  ACC_W  = ACC_W_DEF,
    parameter int  TERMS  = 4,
    localparam int CNT_W  = $clog2(TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    output logic              prod_ready_o,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sum_valid_o,
    input  logic              sum_ready_i,
    output logic              sat_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TERMS - 1);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic             sat;
    logic [CNT_W-1:0] count;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             in_accept;
    logic             out_accept;

    product_accumulator_sat_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_adder (
        .acc      (acc),
        .addend   (prod_i),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Ready is withheld during clear so a product presented alongside an abort is never counted.
    assign prod_ready_o = (state == ACCUM) & ~clear_i;
    assign in_accept    = prod_valid_i & prod_ready_o;
    assign out_accept   = sum_valid_o & sum_ready_i;

    assign sum_valid_o  = (state == RESULT);
    assign sum_o        = acc;
    assign sat_o        = sat;
    assign count_o      = count;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state <= ACCUM;
            acc   <= '0;
            sat   <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_accept) begin
                        acc   <= add_sum;
                        sat   <= sat | add_ovf;
                        count <= count + CNT_W'(1);
                        if (count == LAST_IDX) begin
                            state <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    // No bypass: the cycle that hands off the result cannot also take a product.
                    if (out_accept) begin
                        state <= ACCUM;
                        acc   <= '0;
                        sat   <= 1'b0;
                        count <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
